// File: rtl/pg_rule_filter_pkg.sv
// Shared types and constants for the port-group rule filter.
// Delay-line and output FIFO entries share one packed word layout.
package pg_rule_filter_pkg;

  localparam int PG_AWIDTH      = 6;
  localparam int PGF_RULE_W     = 16;
  localparam int PGF_PU_LATENCY = 12;

  typedef struct packed {
    logic [PGF_RULE_W-1:0] rule_id;
    logic                  id_valid;
    logic                  last;
  } pgf_word_t;

endpackage

// File: rtl/pg_rule_filter_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Output data reads as zero while empty so idle outputs stay clean.
module pgf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_occ;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_occ == '0);
  assign w_full  = (r_occ == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_occ   = r_occ;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(i_push && w_full && !i_pop)
  );

endmodule

// File: rtl/pg_rule_filter.sv
// Issues rule candidates to port_unit, realigns id/last to port_match,
// and queues matching rules plus end-of-packet markers with credit flow.
module pg_rule_filter
  import pg_rule_filter_pkg::*;
#(
  parameter int RULE_W     = PGF_RULE_W,
  parameter int PU_LATENCY = PGF_PU_LATENCY,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RULE_W-1:0]    in_rule_id,
  input  logic [PG_AWIDTH-1:0] in_rule_pg,
  input  logic                 in_rule_last,
  input  logic [15:0]          in_src_port,
  input  logic [15:0]          in_dst_port,
  input  logic                 in_tcp,
  input  logic                 in_rule_valid,
  output logic                 in_rule_ready,
  output logic [PG_AWIDTH-1:0] pu_pg,
  output logic                 pu_pg_valid,
  output logic [15:0]          pu_src_port,
  output logic [15:0]          pu_dst_port,
  output logic                 pu_tcp,
  input  logic                 pu_port_match,
  output logic [RULE_W-1:0]    out_rule_id,
  output logic                 out_id_valid,
  output logic                 out_rule_last,
  output logic                 out_rule_valid,
  input  logic                 out_rule_ready,
  output logic [31:0]          stat_match_cnt,
  output logic [31:0]          stat_drop_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(PU_LATENCY + 1);
  localparam int WW = $bits(pgf_word_t);

  logic                 w_accept;
  logic [PG_AWIDTH-1:0] r_pu_pg;
  logic [15:0]          r_pu_src;
  logic [15:0]          r_pu_dst;
  logic                 r_pu_tcp;

  pgf_word_t            r_dl [PU_LATENCY];
  pgf_word_t            w_in_word;
  pgf_word_t            w_tap;
  logic                 w_tap_v;

  logic                 w_push;
  pgf_word_t            w_push_word;
  logic [IW-1:0]        r_inflight;
  logic [CW-1:0]        w_occ;
  logic                 w_empty;
  logic [WW-1:0]        w_fifo_q;
  pgf_word_t            w_out;
  logic [31:0]          r_match_cnt;
  logic [31:0]          r_drop_cnt;

  assign w_accept    = in_rule_valid & in_rule_ready;
  assign pu_pg_valid = w_accept;
  assign pu_pg       = w_accept ? in_rule_pg  : r_pu_pg;
  assign pu_src_port = w_accept ? in_src_port : r_pu_src;
  assign pu_dst_port = w_accept ? in_dst_port : r_pu_dst;
  assign pu_tcp      = w_accept ? in_tcp      : r_pu_tcp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pu_pg  <= '0;
      r_pu_src <= '0;
      r_pu_dst <= '0;
      r_pu_tcp <= 1'b0;
    end else if (w_accept) begin
      r_pu_pg  <= in_rule_pg;
      r_pu_src <= in_src_port;
      r_pu_dst <= in_dst_port;
      r_pu_tcp <= in_tcp;
    end
  end

  // id_valid inside the delay line marks a live candidate slot.
  assign w_in_word.rule_id  = PGF_RULE_W'(in_rule_id);
  assign w_in_word.id_valid = w_accept;
  assign w_in_word.last     = in_rule_last & w_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PU_LATENCY; k++) r_dl[k] <= '0;
    end else begin
      r_dl[0] <= w_in_word;
      for (int k = 1; k < PU_LATENCY; k++) r_dl[k] <= r_dl[k-1];
    end
  end

  assign w_tap   = r_dl[PU_LATENCY-1];
  assign w_tap_v = w_tap.id_valid;
  assign w_push  = w_tap_v & (pu_port_match | w_tap.last);

  assign w_push_word.rule_id  = w_tap.rule_id;
  assign w_push_word.id_valid = pu_port_match;
  assign w_push_word.last     = w_tap.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      unique case ({w_accept, w_tap_v})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Every inflight candidate holds a reserved FIFO slot.
  assign in_rule_ready =
    (32'(w_occ) + 32'(r_inflight)) < 32'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_cnt <= '0;
      r_drop_cnt  <= '0;
    end else if (w_tap_v) begin
      if (pu_port_match) r_match_cnt <= r_match_cnt + 32'd1;
      else               r_drop_cnt  <= r_drop_cnt + 32'd1;
    end
  end

  assign stat_match_cnt = r_match_cnt;
  assign stat_drop_cnt  = r_drop_cnt;

  pgf_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_word),
    .i_pop   (out_rule_ready),
    .o_data  (w_fifo_q),
    .o_empty (w_empty),
    .o_occ   (w_occ)
  );

  assign w_out          = pgf_word_t'(w_fifo_q);
  assign out_rule_valid = ~w_empty;
  assign out_rule_id    = RULE_W'(w_out.rule_id);
  assign out_id_valid   = w_out.id_valid;
  assign out_rule_last  = w_out.last;

endmodule
